// File: rtl/stage_sequencer.sv
// Multi-cycle Y86-64 stage controller: steps fetch..PC update one stage at a time,
// waits on RAM completion and classifies faults/halts into a Y86 status code.
module stage_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       icode_i,
  input  logic             instr_valid_i,
  input  logic             imem_error_i,
  input  logic             dmem_error_i,
  input  logic             mem_ready_i,
  output logic             ram_instr_rd_o,
  output logic             fetch_en_o,
  output logic             decode_en_o,
  output logic             execute_en_o,
  output logic             mem_rd_o,
  output logic             mem_wr_o,
  output logic             wb_en_o,
  output logic             pc_en_o,
  output logic [2:0]       stat_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instr_count_o
);

  localparam int unsigned WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        stat, stat_nxt;
  logic [3:0]        icode_q, icode_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              wait_limit;
  logic              is_mem, is_rd, is_wr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      stat     <= STAT_AOK;
      icode_q  <= '0;
      wait_cnt <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      stat     <= stat_nxt;
      icode_q  <= icode_nxt;
      wait_cnt <= wait_nxt;
      count    <= count_nxt;
    end
  end

  assign is_rd  = (icode_q == 4'h5) || (icode_q == 4'h9) || (icode_q == 4'hB);
  assign is_wr  = (icode_q == 4'h4) || (icode_q == 4'h8) || (icode_q == 4'hA);
  assign is_mem = is_rd || is_wr;
  assign wait_limit = (MEM_WAIT_MAX != 0) && (wait_cnt == WAIT_W'(MEM_WAIT_MAX));

  // wait_nxt defaults to zero so every state change clears it on entry to FETCH/MEMORY
  always_comb begin
    state_nxt = state;
    stat_nxt  = stat;
    icode_nxt = icode_q;
    wait_nxt  = '0;
    count_nxt = count;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nxt = S_FETCH;
          stat_nxt  = STAT_AOK;
        end
      end
      S_FETCH: begin
        if (mem_ready_i) begin
          if (imem_error_i) begin
            state_nxt = S_HALT;
            stat_nxt  = STAT_ADR;
          end else if (!instr_valid_i) begin
            state_nxt = S_HALT;
            stat_nxt  = STAT_INS;
          end else if (icode_i == 4'h0) begin
            state_nxt = S_HALT;
            stat_nxt  = STAT_HLT;
          end else begin
            icode_nxt = icode_i;
            state_nxt = S_DECODE;
          end
        end else if (wait_limit) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_ADR;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      S_DECODE:  state_nxt = S_EXECUTE;
      S_EXECUTE: state_nxt = is_mem ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        if (mem_ready_i) begin
          if (dmem_error_i) begin
            state_nxt = S_HALT;
            stat_nxt  = STAT_ADR;
          end else begin
            state_nxt = S_WRITEBACK;
          end
        end else if (wait_limit) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_ADR;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      S_WRITEBACK: state_nxt = S_PCUPD;
      S_PCUPD: begin
        count_nxt = count + 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ram_instr_rd_o = 1'b0;
    fetch_en_o     = 1'b0;
    decode_en_o    = 1'b0;
    execute_en_o   = 1'b0;
    mem_rd_o       = 1'b0;
    mem_wr_o       = 1'b0;
    wb_en_o        = 1'b0;
    pc_en_o        = 1'b0;
    case (state)
      S_FETCH: begin
        ram_instr_rd_o = 1'b1;
        fetch_en_o     = 1'b1;
      end
      S_DECODE:  decode_en_o  = 1'b1;
      S_EXECUTE: execute_en_o = 1'b1;
      S_MEMORY: begin
        mem_rd_o = is_rd;
        mem_wr_o = is_wr;
      end
      S_WRITEBACK: wb_en_o = 1'b1;
      S_PCUPD:     pc_en_o = 1'b1;
      default: ;
    endcase
  end

  assign stat_o        = stat;
  assign state_o       = state;
  assign busy_o        = (state != S_IDLE) && (state != S_HALT);
  assign halted_o      = (state == S_HALT);
  assign instr_count_o = count;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: fixed vector table, directed corner cases
// and randomized instruction streams checked against an instruction-level plan model.
module tb_stage_sequencer;

  localparam int WMAX = 15;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXECUTE = 3'd3,
                         ST_MEMORY = 3'd4, ST_WB = 3'd5, ST_PCUPD = 3'd6, ST_HALT = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, valid, ierr, derr, ready;
  logic [3:0] icode;
  logic       ram_instr_rd, fetch_en, decode_en, execute_en, mem_rd, mem_wr, wb_en, pc_en;
  logic [2:0] stat, state;
  logic       busy, halted;
  logic [3:0] count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stage_sequencer #(.MEM_WAIT_MAX(WMAX), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .icode_i(icode),
    .instr_valid_i(valid), .imem_error_i(ierr), .dmem_error_i(derr), .mem_ready_i(ready),
    .ram_instr_rd_o(ram_instr_rd), .fetch_en_o(fetch_en), .decode_en_o(decode_en),
    .execute_en_o(execute_en), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .wb_en_o(wb_en),
    .pc_en_o(pc_en), .stat_o(stat), .busy_o(busy), .halted_o(halted), .state_o(state),
    .instr_count_o(count)
  );

  // One record per clock cycle: expected state/status/count during the cycle plus the inputs to drive
  typedef struct {
    logic [2:0] st;
    logic       start;
    logic [3:0] icode;
    logic       valid, ierr, derr, ready;
    logic [2:0] stat;
    logic [3:0] cnt;
    logic [3:0] icq;
  } step_t;

  step_t      q[$];
  step_t      tbl[15];
  logic [2:0] m_stat;
  int         m_cnt;
  logic [3:0] m_icq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [9:0] exp_outs(input logic [2:0] st, input logic [3:0] icq);
    logic [7:0] s8;
    logic       rd, wr;
    rd = (icq == 4'h5) || (icq == 4'h9) || (icq == 4'hB);
    wr = (icq == 4'h4) || (icq == 4'h8) || (icq == 4'hA);
    s8 = '0;
    case (st)
      ST_FETCH:   s8 = 8'b1100_0000;
      ST_DECODE:  s8 = 8'b0010_0000;
      ST_EXECUTE: s8 = 8'b0001_0000;
      ST_MEMORY:  s8 = {4'b0000, rd, wr, 2'b00};
      ST_WB:      s8 = 8'b0000_0010;
      ST_PCUPD:   s8 = 8'b0000_0001;
      default:    s8 = '0;
    endcase
    return {s8, (st != ST_IDLE) && (st != ST_HALT), st == ST_HALT};
  endfunction

  function automatic step_t mk(input logic [2:0] st, input logic st_in, input logic [3:0] ic,
                               input logic [2:0] sc, input logic [3:0] cn);
    step_t s;
    s.st = st; s.start = st_in; s.icode = ic; s.valid = 1'b1; s.ierr = 1'b0; s.derr = 1'b0;
    s.ready = 1'b1; s.stat = sc; s.cnt = cn; s.icq = 4'h1;
    return s;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [2:0] st, input logic st_in, input logic [3:0] ic,
                      input logic v, input logic ie, input logic de, input logic rd);
    step_t s;
    s.st = st; s.start = st_in; s.icode = ic; s.valid = v; s.ierr = ie; s.derr = de;
    s.ready = rd; s.stat = m_stat; s.cnt = 4'(m_cnt); s.icq = m_icq;
    q.push_back(s);
  endtask

  task automatic junk(input logic [2:0] st);
    push(st, rb(), 4'($urandom), rb(), rb(), rb(), rb());
  endtask

  task automatic plan_start();
    push(ST_IDLE, 1'b0, 4'($urandom), rb(), rb(), rb(), rb());
    push(ST_IDLE, 1'b1, 4'($urandom), rb(), rb(), rb(), rb());
  endtask

  task automatic plan_halt(input int n);
    for (int i = 0; i < n; i++) junk(ST_HALT);
  endtask

  // Model of one instruction: fw/dw = idle cycles before mem_ready in FETCH/MEMORY
  task automatic plan_instr(input logic [3:0] ic, input logic v, input logic ie, input logic de,
                            input int fw, input int dw, output bit halted);
    halted = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (k >= fw) begin
        push(ST_FETCH, rb(), ic, v, ie, rb(), 1'b1);
        break;
      end
      push(ST_FETCH, rb(), 4'($urandom), rb(), rb(), rb(), 1'b0);
      if (k == WMAX) begin m_stat = 3'd3; halted = 1'b1; return; end
    end
    if (ie)            begin m_stat = 3'd3; halted = 1'b1; return; end
    if (!v)            begin m_stat = 3'd4; halted = 1'b1; return; end
    if (ic == 4'h0)    begin m_stat = 3'd2; halted = 1'b1; return; end
    m_icq = ic;
    junk(ST_DECODE);
    junk(ST_EXECUTE);
    if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
      for (int k = 0; k < 64; k++) begin
        if (k >= dw) begin
          push(ST_MEMORY, rb(), 4'($urandom), rb(), rb(), de, 1'b1);
          break;
        end
        push(ST_MEMORY, rb(), 4'($urandom), rb(), rb(), 1'b0, 1'b0);
        if (k == WMAX) begin m_stat = 3'd3; halted = 1'b1; return; end
      end
      if (de) begin m_stat = 3'd3; halted = 1'b1; return; end
    end
    junk(ST_WB);
    junk(ST_PCUPD);
    m_cnt++;
  endtask

  task automatic run_steps();
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("state[%0d]", i), 32'(state), 32'(q[i].st));
      chk($sformatf("outs[%0d]", i),
          32'({ram_instr_rd, fetch_en, decode_en, execute_en, mem_rd, mem_wr, wb_en, pc_en, busy, halted}),
          32'(exp_outs(q[i].st, q[i].icq)));
      chk($sformatf("stat[%0d]", i), 32'(stat), 32'(q[i].stat));
      chk($sformatf("count[%0d]", i), 32'(count), 32'(q[i].cnt));
      start = q[i].start; icode = q[i].icode; valid = q[i].valid;
      ierr = q[i].ierr; derr = q[i].derr; ready = q[i].ready;
    end
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; icode = '0; valid = 1'b0; ierr = 1'b0; derr = 1'b0; ready = 1'b0;
    #3 rst = 1'b0;
    m_stat = 3'd1; m_cnt = 0; m_icq = '0;
  endtask

  initial begin
    bit h;
    int r;
    rst = 1'b1; start = 1'b0; icode = '0; valid = 1'b0; ierr = 1'b0; derr = 1'b0; ready = 1'b0;

    // nop stream with ready tied high, then halt on icode 0 and ignore start in HALT
    tbl[0]  = mk(ST_IDLE,    1'b0, 4'h1, 3'd1, 4'd0);
    tbl[1]  = mk(ST_IDLE,    1'b1, 4'h1, 3'd1, 4'd0);
    tbl[2]  = mk(ST_FETCH,   1'b0, 4'h1, 3'd1, 4'd0);
    tbl[3]  = mk(ST_DECODE,  1'b0, 4'h1, 3'd1, 4'd0);
    tbl[4]  = mk(ST_EXECUTE, 1'b0, 4'h1, 3'd1, 4'd0);
    tbl[5]  = mk(ST_WB,      1'b0, 4'h1, 3'd1, 4'd0);
    tbl[6]  = mk(ST_PCUPD,   1'b0, 4'h1, 3'd1, 4'd0);
    tbl[7]  = mk(ST_FETCH,   1'b1, 4'h1, 3'd1, 4'd1);
    tbl[8]  = mk(ST_DECODE,  1'b0, 4'h1, 3'd1, 4'd1);
    tbl[9]  = mk(ST_EXECUTE, 1'b0, 4'h1, 3'd1, 4'd1);
    tbl[10] = mk(ST_WB,      1'b0, 4'h1, 3'd1, 4'd1);
    tbl[11] = mk(ST_PCUPD,   1'b0, 4'h1, 3'd1, 4'd1);
    tbl[12] = mk(ST_FETCH,   1'b0, 4'h0, 3'd1, 4'd2);
    tbl[13] = mk(ST_HALT,    1'b1, 4'h1, 3'd2, 4'd2);
    tbl[14] = mk(ST_HALT,    1'b1, 4'h1, 3'd2, 4'd2);

    do_reset();
    for (int i = 0; i < 15; i++) q.push_back(tbl[i]);
    run_steps();

    // memory instructions: read, write, non-memory
    do_reset();
    plan_start();
    plan_instr(4'h5, 1'b1, 1'b0, 1'b0, 0, 0, h);
    plan_instr(4'hA, 1'b1, 1'b0, 1'b0, 0, 0, h);
    plan_instr(4'h8, 1'b1, 1'b0, 1'b0, 0, 3, h);
    plan_instr(4'h2, 1'b1, 1'b0, 1'b0, 2, 0, h);
    run_steps();

    // ready on the limit cycle proceeds; one cycle later times out with ADR
    do_reset();
    plan_start();
    plan_instr(4'h1, 1'b1, 1'b0, 1'b0, WMAX, 0, h);
    plan_instr(4'h1, 1'b1, 1'b0, 1'b0, WMAX + 1, 0, h);
    plan_halt(3);
    run_steps();

    // memory-stage timeout
    do_reset();
    plan_start();
    plan_instr(4'h9, 1'b1, 1'b0, 1'b0, 0, WMAX + 1, h);
    plan_halt(2);
    run_steps();

    // illegal instruction
    do_reset();
    plan_start();
    plan_instr(4'h1, 1'b1, 1'b0, 1'b0, 0, 0, h);
    plan_instr(4'h2, 1'b0, 1'b0, 1'b0, 1, 0, h);
    plan_halt(2);
    run_steps();

    // fetch address fault outranks invalid/halt
    do_reset();
    plan_start();
    plan_instr(4'h0, 1'b0, 1'b1, 1'b0, 0, 0, h);
    plan_halt(2);
    run_steps();

    // data fault with ready in MEMORY for pushq-style write: no writeback/PC update
    do_reset();
    plan_start();
    plan_instr(4'h4, 1'b1, 1'b0, 1'b1, 0, 2, h);
    plan_halt(3);
    run_steps();

    // counter wrap (4-bit) then asynchronous reset in the middle of MEMORY
    do_reset();
    plan_start();
    for (int i = 0; i < 17; i++) plan_instr(4'h1, 1'b1, 1'b0, 1'b0, 0, 0, h);
    push(ST_FETCH, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1);
    m_icq = 4'h4;
    push(ST_DECODE, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    push(ST_EXECUTE, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    push(ST_MEMORY, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_steps();
    #2 rst = 1'b1;
    #1;
    chk("async_state", 32'(state), 32'(ST_IDLE));
    chk("async_strobes", 32'({ram_instr_rd, fetch_en, decode_en, execute_en, mem_rd, mem_wr, wb_en, pc_en, busy, halted}), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_stat", 32'(stat), 32'd1);
    #1 rst = 1'b0;

    // randomized instruction streams
    for (int it = 0; it < 12; it++) begin
      do_reset();
      plan_start();
      h = 1'b0;
      for (int n = 0; n < 30 && !h; n++) begin
        logic [3:0] ic;
        r  = $urandom_range(0, 99);
        ic = (r < 4) ? 4'h0 : 4'($urandom_range(1, 11));
        plan_instr(ic, $urandom_range(0, 49) != 0, $urandom_range(0, 49) == 0,
                   $urandom_range(0, 29) == 0,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, WMAX + 2) : 0,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, WMAX + 2) : 0, h);
      end
      if (h) plan_halt(2);
      run_steps();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Multi-cycle controller that sequences the Y86-64 datapath stages (fetch, decode, execute, memory, writeback, PC update) one at a time. It drives per-stage enables and the RAM instruction/data request strobes, waits on RAM completion, and classifies fault and halt conditions into a Y86 status code. It sits above the stage modules and the shared RAM, replacing free-running single-cycle operation.

Parameters:
MEM_WAIT_MAX, 15, max cycles waiting on mem_ready_i per access before ADR fault; 0 disables the timeout
CNT_W, 32, width of the retired-instruction counter

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous reset, active-high
start_i  in  1  leave IDLE and begin fetching
icode_i  in  4  icode from fetch stage; sampled at fetch completion
instr_valid_i  in  1  fetch decoded a legal instruction
imem_error_i  in  1  fetch address fault
dmem_error_i  in  1  data access fault from RAM/memory stage
mem_ready_i  in  1  RAM completed the current instruction or data access
ram_instr_rd_o  out  1  instruction read request (FETCH)
fetch_en_o  out  1  latch fetch outputs
decode_en_o  out  1  register-file read strobe
execute_en_o  out  1  ALU/CC update strobe
mem_rd_o  out  1  data read request
mem_wr_o  out  1  data write request
wb_en_o  out  1  register-file write strobe
pc_en_o  out  1  PC update strobe
stat_o  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
busy_o  out  1  state not IDLE and not HALT
halted_o  out  1  state is HALT
state_o  out  3  current state encoding
instr_count_o  out  CNT_W  retired instructions

Behaviour:
- Reset (async, rst_i=1): state IDLE, stat_o=1, instr_count_o=0, icode_q=0, wait counter=0, all strobes 0, busy_o=0, halted_o=0. Reset mid-instruction aborts immediately; no strobe survives the reset edge.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, PCUPD=6, HALT=7.
- All outputs decode from registered state/icode_q only; no combinational input-to-output path.
- IDLE: start_i=1 -> FETCH, stat_o=1. Otherwise stay.
- FETCH: ram_instr_rd_o=1, fetch_en_o=1. When mem_ready_i=1, in priority order: imem_error_i -> HALT, stat 3; !instr_valid_i -> HALT, stat 4; icode_i==0 -> HALT, stat 2; else latch icode_q and go to DECODE.
- DECODE: decode_en_o=1, one cycle -> EXECUTE.
- EXECUTE: execute_en_o=1, one cycle. Goes to MEMORY if icode_q is in {4,5,8,9,A,B}, else WRITEBACK.
- MEMORY: mem_rd_o=1 for icode_q in {5,9,B}; mem_wr_o=1 for {4,8,A}. On mem_ready_i=1: dmem_error_i -> HALT, stat 3, with no writeback or PC update; else WRITEBACK.
- WRITEBACK: wb_en_o=1, one cycle -> PCUPD.
- PCUPD: pc_en_o=1, instr_count_o+1 (wraps modulo 2^CNT_W), then FETCH.
- HALT: sticky until reset. start_i is ignored and all strobes are 0.
- Wait counter:
  - Cleared on entry to FETCH or MEMORY.
  - Increments each cycle in those states while mem_ready_i=0.
  - If it equals MEM_WAIT_MAX with mem_ready_i=0 and MEM_WAIT_MAX!=0 -> HALT, stat 3.
  - If mem_ready_i rises in the same cycle the limit is reached, ready wins.
- Simultaneous mem_ready_i and dmem_error_i: the error wins.
- Latency with mem_ready_i tied high: non-memory instruction = 5 cycles (FETCH through PCUPD); memory instruction = 6 cycles.
- start_i asserted outside IDLE has no effect.

Test Plan:
- Reset, then start_i pulse with mem_ready_i=1 and icode 1 (nop) stream -> state sequence 1,2,3,5,6,1; pc_en_o every 5th cycle; instr_count_o=3 after 15 cycles.
- icode 5 (mrmovq), mem_ready_i=1 -> MEMORY visited with mem_rd_o=1 and mem_wr_o=0; icode A (pushq) -> mem_wr_o=1; 6-cycle period.
- Fetch icode 0 -> HALT, stat_o=2, halted_o=1, busy_o=0; later start_i -> remains HALT; instr_count_o unchanged.
- mem_ready_i held 0 in FETCH with MEM_WAIT_MAX=15 -> HALT with stat_o=3 exactly 16 cycles after entering FETCH. Ready arriving on the limit cycle -> proceeds to DECODE, stat_o=1.
- Fault classification:
  - instr_valid_i=0 at fetch -> stat 4.
  - dmem_error_i with mem_ready_i in MEMORY for icode 4 -> stat 3, with wb_en_o and pc_en_o never asserted.
- rst_i asserted asynchronously mid-MEMORY -> strobes drop without a clock edge, state_o=0, count=0, stat_o=1.
